// File: rtl/present_encryptor_core_if.sv
// Host-side bus of the PRESENT-80 encryptor: shared key/plaintext input,
// load strobes, ciphertext register and completion pulse.
interface present_encryptor_core_if;
  logic [79:0] data_i;
  logic        key_load;
  logic        data_load;
  logic [63:0] data_o;
  logic        done_o;

  modport master (
    output data_i,
    output key_load,
    output data_load,
    input  data_o,
    input  done_o
  );

  modport slave (
    input  data_i,
    input  key_load,
    input  data_load,
    output data_o,
    output done_o
  );
endinterface

// File: rtl/present_encryptor_core.sv
// Iterative PRESENT-80 encryption core: one round per clock, 31 rounds plus a
// final whitening edge, so ciphertext appears 32 edges after data_load.
module present_encryptor_core (
  input  logic                            clk_i,
  input  logic                            rst_i,
  present_encryptor_core_if.slave         bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_e;

  fsm_e        fsm_q,        fsm_d;
  logic [79:0] master_key_q, master_key_d;
  logic [79:0] round_key_q,  round_key_d;
  logic [63:0] state_q,      state_d;
  logic [4:0]  round_ctr_q,  round_ctr_d;
  logic [63:0] data_o_q,     data_o_d;
  logic        done_q,       done_d;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = 64'h0;
    for (int n = 0; n < 16; n++) begin
      y[n*4 +: 4] = sbox(x[n*4 +: 4]);
    end
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = 64'h0;
    for (int j = 0; j < 63; j++) begin
      y[6'((j * 16) % 63)] = x[j];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Rotate left by 61 is the same as rotate right by 19 on an 80-bit word.
  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q        <= ST_IDLE;
      master_key_q <= 80'h0;
      round_key_q  <= 80'h0;
      state_q      <= 64'h0;
      round_ctr_q  <= 5'd0;
      data_o_q     <= 64'h0;
      done_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      master_key_q <= master_key_d;
      round_key_q  <= round_key_d;
      state_q      <= state_d;
      round_ctr_q  <= round_ctr_d;
      data_o_q     <= data_o_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic: loads take priority over an active run, key_load over data_load.
  always_comb begin
    fsm_d        = fsm_q;
    master_key_d = master_key_q;
    round_key_d  = round_key_q;
    state_d      = state_q;
    round_ctr_d  = round_ctr_q;
    data_o_d     = data_o_q;
    done_d       = 1'b0;
    if (bus.key_load) begin
      master_key_d = bus.data_i;
      round_key_d  = bus.data_i;
      fsm_d        = ST_IDLE;
    end else if (bus.data_load) begin
      state_d      = bus.data_i[63:0];
      round_key_d  = master_key_q;
      round_ctr_d  = 5'd1;
      fsm_d        = ST_RUN;
    end else if (fsm_q == ST_RUN) begin
      // Counter wraps 31 -> 0; a zero count while running marks the whitening edge.
      if (round_ctr_q == 5'd0) begin
        data_o_d = state_q ^ round_key_q[79:16];
        done_d   = 1'b1;
        fsm_d    = ST_IDLE;
      end else begin
        state_d     = p_layer(s_layer(state_q ^ round_key_q[79:16]));
        round_key_d = key_upd(round_key_q, round_ctr_q);
        round_ctr_d = round_ctr_q + 5'd1;
      end
    end else begin
      fsm_d = ST_IDLE;
    end
  end

  assign bus.data_o = data_o_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_present_encryptor_core.sv
// Self-checking bench for present_encryptor_core: published PRESENT-80 vectors,
// latency, restart, reset abort and load-priority cases via a ciphertext scoreboard.
module tb_present_encryptor_core;

  localparam logic [79:0] KEY_ZERO = 80'h0;
  localparam logic [79:0] KEY_ONES = 80'hFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [63:0] PT_ZERO  = 64'h0;
  localparam logic [63:0] PT_ONES  = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] CT_K0_P0 = 64'h5579C1387B228445;
  localparam logic [63:0] CT_K1_P0 = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_K0_P1 = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT_K1_P1 = 64'h3333DCD3213210D2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  present_encryptor_core_if bus();

  present_encryptor_core dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];

  task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (bus.done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 80'd1, 80'd0);
      end else begin
        logic [63:0] exp_ct;
        exp_ct = sb_q.pop_front();
        check_val("ciphertext", {16'h0, bus.data_o}, {16'h0, exp_ct});
      end
    end
  end

  task automatic load_key(input logic [79:0] k);
    @(negedge clk_i);
    bus.data_i   = k;
    bus.key_load = 1'b1;
    @(negedge clk_i);
    bus.key_load = 1'b0;
    bus.data_i   = 80'h0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      if (bus.done_o === 1'b1) break;
    end
    check_val(tag, 80'(cyc), 80'd32);
  endtask

  // Upper data_i bits carry junk to show they are ignored for plaintext.
  task automatic run_enc(input logic [63:0] pt, input logic [63:0] exp_ct, input string tag);
    @(negedge clk_i);
    bus.data_i    = {16'hA5A5, pt};
    bus.data_load = 1'b1;
    sb_q.push_back(exp_ct);
    @(negedge clk_i);
    bus.data_load = 1'b0;
    bus.data_i    = 80'h0;
    wait_done({tag, "_latency"});
    @(negedge clk_i);
    check_val({tag, "_done_pulse"}, {79'h0, bus.done_o}, 80'd0);
    check_val({tag, "_hold"}, {16'h0, bus.data_o}, {16'h0, exp_ct});
  endtask

  initial begin
    bus.data_i    = 80'h0;
    bus.key_load  = 1'b0;
    bus.data_load = 1'b0;
    rst_i         = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check_val("reset_data_o", {16'h0, bus.data_o}, 80'h0);
    check_val("reset_done_o", {79'h0, bus.done_o}, 80'h0);

    load_key(KEY_ZERO);
    run_enc(PT_ZERO, CT_K0_P0, "k0_p0");
    run_enc(PT_ONES, CT_K0_P1, "k0_p1");
    run_enc(PT_ONES, CT_K0_P1, "k0_p1_again");
    repeat (5) @(negedge clk_i);
    check_val("idle_hold", {16'h0, bus.data_o}, {16'h0, CT_K0_P1});

    load_key(KEY_ONES);
    check_val("key_load_keeps_data_o", {16'h0, bus.data_o}, {16'h0, CT_K0_P1});
    run_enc(PT_ZERO, CT_K1_P0, "k1_p0");
    run_enc(PT_ONES, CT_K1_P1, "k1_p1");

    // Restart: the first run is discarded and produces no done_o.
    @(negedge clk_i);
    bus.data_i    = {16'h0, PT_ZERO};
    bus.data_load = 1'b1;
    @(negedge clk_i);
    bus.data_load = 1'b0;
    repeat (5) @(negedge clk_i);
    run_enc(PT_ONES, CT_K1_P1, "restart");

    // Reset during round 10 aborts the run and clears the master key.
    @(negedge clk_i);
    bus.data_i    = {16'h0, PT_ONES};
    bus.data_load = 1'b1;
    @(negedge clk_i);
    bus.data_load = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_val("midrun_reset_data_o", {16'h0, bus.data_o}, 80'h0);
    check_val("midrun_reset_done_o", {79'h0, bus.done_o}, 80'h0);
    repeat (40) @(negedge clk_i);
    check_val("midrun_reset_no_result", {16'h0, bus.data_o}, 80'h0);
    run_enc(PT_ZERO, CT_K0_P0, "after_reset_key_cleared");

    // key_load and data_load together: key only, no encryption starts.
    @(negedge clk_i);
    bus.data_i    = KEY_ONES;
    bus.key_load  = 1'b1;
    bus.data_load = 1'b1;
    @(negedge clk_i);
    bus.key_load  = 1'b0;
    bus.data_load = 1'b0;
    bus.data_i    = 80'h0;
    repeat (40) @(negedge clk_i);
    check_val("both_loads_no_run", {16'h0, bus.data_o}, {16'h0, CT_K0_P0});
    run_enc(PT_ZERO, CT_K1_P0, "both_loads_key_taken");

    check_val("scoreboard_drained", 80'(sb_q.size()), 80'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
